rotator_sequencer: RTL and testbench
====================================

// Module: rotator_sequencer
// PURPOSE
//  Command sequencer for the WIDTH-bit rotating shift register datapath.
//  Takes commands over a valid/ready handshake: LOAD, rotate-left N, rotate-right N, arithmetic-shift-right N.
//  Expands each command into per-cycle control strobes for the register, and can also step the register
//  autonomously (marquee mode) at a programmable period. Sits between board-level control and the register.
// PARAMETERS
//  WIDTH     8   register/data width
//  CNT_W     4   width of step count (max 2**CNT_W-1 steps per command)
//  PERIOD_W  24  width of auto-step period counter
// PORTS
//  clock        in   1         clock; all state updates on posedge
//  reset        in   1         synchronous, active-high
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         sequencer can accept (1 only in IDLE)
//  cmd_op       in   2         00 LOAD, 01 ROTL, 10 ROTR, 11 ASR
//  cmd_data     in   WIDTH     load value (LOAD only)
//  cmd_count    in   CNT_W     number of single-bit steps (shift ops only)
//  auto_en      in   1         enable autonomous stepping while IDLE
//  auto_period  in   PERIOD_W  cycles between auto steps; 0 treated as 1
//  auto_dir     in   1         auto step direction: 0 left, 1 right (rotate)
//  reg_en       out  1         register update enable this cycle
//  reg_load     out  1         1: register loads reg_din; 0: register shifts
//  reg_right    out  1         shift direction: 0 left (bit i <- bit i-1, LSB <- MSB), 1 right
//  reg_asr      out  1         with reg_right=1: MSB <- MSB (sign fill) instead of LSB
//  reg_din      out  WIDTH     load data
//  busy         out  1         command in progress (state != IDLE)
//  done         out  1         one-cycle pulse at command completion
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1; step and period counters cleared.
//   Reset mid-command aborts it: no further reg_en, no done pulse.
//  All reg_* outputs are registered; register samples them at the next posedge when reg_en=1.
//  States: IDLE, LOAD, SHIFT, DONE.
//   IDLE: cmd_ready=1. Accept on posedge with cmd_valid&cmd_ready; latch op/data/count.
//    LOAD -> LOAD; shift op with count>0 -> SHIFT; shift op with count=0 -> DONE.
//   LOAD: exactly 1 cycle, reg_en=1, reg_load=1, reg_din=latched data -> DONE.
//   SHIFT: reg_en=1, reg_load=0 for exactly count consecutive cycles; reg_right=1 for ROTR/ASR;
//    reg_asr=1 for ASR only. Remaining count decrements each cycle; -> DONE after last step.
//   DONE: 1 cycle, done=1, busy=1, cmd_ready=0, reg_en=0 -> IDLE.
//  Latency: accept at edge E -> first reg_en cycle immediately after E; done in cycle after last step.
//   Back-to-back commands: next accept earliest at the edge ending the DONE cycle + 1 (IDLE cycle).
//  Inputs changing while busy are ignored (latched copies used).
//  Auto mode (IDLE only, auto_en=1): period counter counts cycles; when it reaches
//   max(auto_period,1)-1 it wraps to 0 and emits one reg_en cycle: reg_load=0, reg_right=auto_dir, reg_asr=0.
//   Auto steps do not assert busy or done.
//  Priority: command accepted on the same edge an auto step would fire -> command wins, auto step dropped.
//  Period counter clears on command accept, when auto_en=0, and when leaving IDLE; restarts from 0 on return.
//  reg_asr=0 whenever reg_right=0 or reg_load=1. reg_din holds last loaded value otherwise.
// TESTING
//  1. LOAD 0xA5 then ROTL count 3 -> reg_en 1 cycle (load) then 3 cycles; modelled register 0x2D; done pulses once each.
//  2. LOAD 0x81, ROTR 1 -> register 0xC0; LOAD 0x80, ASR 2 -> register 0xE0, reg_asr=1 only in the 2 step cycles.
//  3. ROTL count 0 -> no reg_en, done pulse on cycle after accept, cmd_ready back to 1 next cycle.
//  4. auto_en=1, auto_period=4, auto_dir=0 from 0x01 -> reg_en every 4th cycle, register 0x02,0x04,...; period 0 -> every cycle.
//  5. cmd_valid asserted on an auto-step cycle -> command accepted, auto step suppressed, period counter restarts after DONE.
//  6. reset asserted 2 cycles into ROTR count 5 -> reg_en 0 next cycle, no done, cmd_ready=1, busy=0.

Source files
------------

// File: rtl/rotator_sequencer.sv
// Command sequencer for a rotating shift register: turns LOAD/ROTL/ROTR/ASR commands
// into registered per-cycle control strobes, with an optional free-running marquee step.
module rotator_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [WIDTH-1:0]    cmd_data,
  input  logic [CNT_W-1:0]    cmd_count,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] auto_period,
  input  logic                auto_dir,
  output logic                reg_en,
  output logic                reg_load,
  output logic                reg_right,
  output logic                reg_asr,
  output logic [WIDTH-1:0]    reg_din,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ROTL = 2'b01, OP_ROTR = 2'b10, OP_ASR = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
  localparam logic [CNT_W-1:0]    COUNT_ONE  = CNT_W'(1);

  state_e              state;
  op_e                 op_q;
  logic [CNT_W-1:0]    remaining;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period_last;
  logic                accept;

  // A zero period behaves like a period of one: step every cycle.
  assign period_last = (auto_period == '0) ? '0 : auto_period - PERIOD_ONE;
  assign accept      = (state == S_IDLE) && cmd_valid;

  // NOTE: every output is a flop computed for the state being entered, so all
  // assignments here are non-blocking; strobes default low and are re-asserted
  // only where needed, which also keeps reg_asr low whenever reg_right or reg_load is.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_LOAD;
      remaining  <= '0;
      period_cnt <= '0;
      cmd_ready  <= 1'b1;
      reg_en     <= 1'b0;
      reg_load   <= 1'b0;
      reg_right  <= 1'b0;
      reg_asr    <= 1'b0;
      reg_din    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      reg_en    <= 1'b0;
      reg_load  <= 1'b0;
      reg_right <= 1'b0;
      reg_asr   <= 1'b0;
      done      <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            period_cnt <= '0;
            op_q       <= op_e'(cmd_op);
            remaining  <= cmd_count;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            if (op_e'(cmd_op) == OP_LOAD) begin
              state    <= S_LOAD;
              reg_en   <= 1'b1;
              reg_load <= 1'b1;
              reg_din  <= cmd_data;
            end else if (cmd_count != '0) begin
              state     <= S_SHIFT;
              reg_en    <= 1'b1;
              reg_right <= (op_e'(cmd_op) != OP_ROTL);
              reg_asr   <= (op_e'(cmd_op) == OP_ASR);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (auto_en) begin
            if (period_cnt >= period_last) begin
              period_cnt <= '0;
              reg_en     <= 1'b1;
              reg_right  <= auto_dir;
            end else begin
              period_cnt <= period_cnt + PERIOD_ONE;
            end
          end else begin
            period_cnt <= '0;
          end
        end

        S_LOAD: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_SHIFT: begin
          if (remaining == COUNT_ONE) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            remaining <= remaining - COUNT_ONE;
            reg_en    <= 1'b1;
            reg_right <= (op_q != OP_ROTL);
            reg_asr   <= (op_q == OP_ASR);
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          period_cnt <= '0;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotator_sequencer.sv
// Directed bench for rotator_sequencer: drives commands and marquee mode, and checks
// the strobes against a behavioural model of the shift register they control.
module tb_rotator_sequencer;

  localparam int WIDTH    = 8;
  localparam int CNT_W    = 4;
  localparam int PERIOD_W = 24;

  logic                clock = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [WIDTH-1:0]    cmd_data;
  logic [CNT_W-1:0]    cmd_count;
  logic                auto_en;
  logic [PERIOD_W-1:0] auto_period;
  logic                auto_dir;
  logic                reg_en, reg_load, reg_right, reg_asr;
  logic [WIDTH-1:0]    reg_din;
  logic                busy, done;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0, done_cnt = 0, asr_cnt = 0;
  int en0, done0, asr0;
  logic [WIDTH-1:0] model = '0;

  rotator_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PERIOD_W(PERIOD_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count),
    .auto_en(auto_en), .auto_period(auto_period), .auto_dir(auto_dir),
    .reg_en(reg_en), .reg_load(reg_load), .reg_right(reg_right), .reg_asr(reg_asr),
    .reg_din(reg_din), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Shift register being controlled, plus strobe activity counters.
  always @(posedge clock) begin
    if (reg_en) begin
      en_cnt <= en_cnt + 1;
      if (reg_load)       model <= reg_din;
      else if (!reg_right) model <= {model[WIDTH-2:0], model[WIDTH-1]};
      else if (reg_asr)    model <= {model[WIDTH-1], model[WIDTH-1:1]};
      else                 model <= {model[0], model[WIDTH-1:1]};
      if (reg_asr) asr_cnt <= asr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic mark();
    en0 = en_cnt; done0 = done_cnt; asr0 = asr_cnt;
  endtask

  // Issue one command, scramble the inputs while busy, wait for done, return in IDLE.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [CNT_W-1:0] count);
    logic seen;
    mark();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = count;
    step();
    cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~data; cmd_count = '1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else step();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    step();
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    auto_en = 1'b0; auto_period = '0; auto_dir = 1'b0;
    step(); step();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_reg_en", 32'(reg_en), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_din",   32'(reg_din), 32'd0);
    reset = 1'b0;
    step();

    // LOAD 0xA5 then ROTL 3
    do_cmd("load_a5", 2'b00, 8'hA5, 4'd0);
    check("load_a5_en",   32'(en_cnt - en0), 32'd1);
    check("load_a5_doneN", 32'(done_cnt - done0), 32'd1);
    check("load_a5_reg",  32'(model), 32'hA5);
    do_cmd("rotl3", 2'b01, 8'h00, 4'd3);
    check("rotl3_en",    32'(en_cnt - en0), 32'd3);
    check("rotl3_doneN", 32'(done_cnt - done0), 32'd1);
    check("rotl3_reg",   32'(model), 32'h2D);

    // ROTR and ASR
    do_cmd("load_81", 2'b00, 8'h81, 4'd0);
    do_cmd("rotr1", 2'b10, 8'h00, 4'd1);
    check("rotr1_reg", 32'(model), 32'hC0);
    do_cmd("load_80", 2'b00, 8'h80, 4'd0);
    check("load_80_asr", 32'(asr_cnt - asr0), 32'd0);
    do_cmd("asr2", 2'b11, 8'h00, 4'd2);
    check("asr2_reg",  32'(model), 32'hE0);
    check("asr2_asrN", 32'(asr_cnt - asr0), 32'd2);
    check("asr2_en",   32'(en_cnt - en0), 32'd2);

    // Zero-count shift: straight to DONE
    mark();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd0;
    step();
    cmd_valid = 1'b0;
    check("cnt0_reg_en", 32'(reg_en), 32'd0);
    check("cnt0_done",   32'(done), 32'd1);
    check("cnt0_busy",   32'(busy), 32'd1);
    check("cnt0_ready",  32'(cmd_ready), 32'd0);
    step();
    check("cnt0_ready_back", 32'(cmd_ready), 32'd1);
    check("cnt0_done_low",   32'(done), 32'd0);
    check("cnt0_en",         32'(en_cnt - en0), 32'd0);

    // Marquee, period 4, left, from 0x01
    do_cmd("load_01", 2'b00, 8'h01, 4'd0);
    auto_en = 1'b1; auto_period = 24'd4; auto_dir = 1'b0;
    mark();
    step(); step(); step();
    check("auto4_quiet", 32'(reg_en), 32'd0);
    step();
    check("auto4_fire",  32'(reg_en), 32'd1);
    check("auto4_right", 32'(reg_right), 32'd0);
    check("auto4_busy",  32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("auto4_en",  32'(en_cnt - en0), 32'd3);
    check("auto4_reg", 32'(model), 32'h08);
    check("auto4_fire4", 32'(reg_en), 32'd1);
    auto_en = 1'b0;
    step();
    check("auto4_reg_final", 32'(model), 32'h10);
    check("auto_off_en", 32'(reg_en), 32'd0);
    check("auto4_no_done", 32'(done_cnt - done0), 32'd0);

    // Period 0 behaves as 1
    auto_en = 1'b1; auto_period = 24'd0;
    step();
    check("auto0_fire", 32'(reg_en), 32'd1);
    step(); step(); step(); step();
    check("auto0_reg", 32'(model), 32'h01);
    auto_en = 1'b0;
    step();
    check("auto0_reg_final", 32'(model), 32'h02);

    // Command collides with an auto step: command wins, counter restarts after DONE
    auto_en = 1'b1; auto_period = 24'd4; auto_dir = 1'b1;
    step(); step(); step();
    check("coll_quiet", 32'(reg_en), 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd1;
    step();
    cmd_valid = 1'b0;
    check("coll_busy",  32'(busy), 32'd1);
    check("coll_right", 32'(reg_right), 32'd0);
    step();
    check("coll_done", 32'(done), 32'd1);
    check("coll_reg",  32'(model), 32'h04);
    step();
    check("coll_ready", 32'(cmd_ready), 32'd1);
    step(); step(); step();
    check("coll_restart_quiet", 32'(reg_en), 32'd0);
    step();
    check("coll_restart_fire",  32'(reg_en), 32'd1);
    check("coll_restart_right", 32'(reg_right), 32'd1);
    auto_en = 1'b0;
    step();
    check("coll_reg_final", 32'(model), 32'h02);

    // Reset two cycles into ROTR 5
    mark();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd5;
    step();
    cmd_valid = 1'b0;
    step();
    check("abort_mid_en", 32'(reg_en), 32'd1);
    reset = 1'b1;
    step();
    check("abort_reg_en", 32'(reg_en), 32'd0);
    check("abort_ready",  32'(cmd_ready), 32'd1);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_reg",    32'(model), 32'h80);
    reset = 1'b0;
    step(); step(); step();
    check("abort_no_done", 32'(done_cnt - done0), 32'd0);
    check("abort_en",      32'(en_cnt - en0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
